// File: rtl/uart_frame_parser_if.sv
// Signal bundle between the UART receiver / command decoder and the frame parser.
// The parser takes the slave side; the byte source and frame consumer take the master side.
interface uart_frame_parser_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        data_in;
  logic              data_rcvd;
  logic              dataerror;
  logic              frameerror;
  logic              parity_en;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_valid;
  logic [7:0]        cmd;
  logic [7:0]        len;
  logic              err_pulse;
  logic [2:0]        err_code;

  modport master (
    output data_in, data_rcvd, dataerror, frameerror, parity_en, frame_ack, rd_addr,
    input  rd_data, frame_valid, cmd, len, err_pulse, err_code
  );

  modport slave (
    input  data_in, data_rcvd, dataerror, frameerror, parity_en, frame_ack, rd_addr,
    output rd_data, frame_valid, cmd, len, err_pulse, err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Command frame parser: hunts for a two-byte header, collects CMD/LEN/payload/checksum,
// and holds a validated frame for the command decoder until it is acknowledged.
module uart_frame_parser #(
  parameter logic [7:0] HDR0    = 8'h55,
  parameter logic [7:0] HDR1    = 8'hAA,
  parameter int         MAX_LEN = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 2048
) (
  input logic               baud_clk,
  input logic               rst,
  uart_frame_parser_if.slave bus
);

  localparam logic [2:0] HUNT0   = 3'd0;
  localparam logic [2:0] HUNT1   = 3'd1;
  localparam logic [2:0] CMD     = 3'd2;
  localparam logic [2:0] LEN     = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;
  localparam logic [2:0] CHK     = 3'd5;
  localparam logic [2:0] HOLD    = 3'd6;

  localparam logic [2:0] ERR_CHECKSUM = 3'd1;
  localparam logic [2:0] ERR_LINE     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_LENGTH   = 3'd4;
  localparam logic [2:0] ERR_OVERRUN  = 3'd5;

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [7:0]       cmd_r;
  logic [7:0]       len_r;
  logic [7:0]       sum;
  logic [7:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             frame_valid;
  logic [7:0]       cmd;
  logic [7:0]       len;
  logic             err_pulse;
  logic [2:0]       err_code;
  logic [7:0]       buf_mem [2**ADDR_W];

  logic byte_evt;
  logic bad_byte;
  logic good_byte;

  assign byte_evt  = bus.data_rcvd;
  assign bad_byte  = bus.data_rcvd & (bus.frameerror | (bus.parity_en & bus.dataerror));
  assign good_byte = byte_evt & ~bad_byte;

  // HOLD owns the frame: every byte there is an overrun, and the ack is still honoured.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT0;
      frame_valid <= 1'b0;
      cmd         <= 8'h00;
      len         <= 8'h00;
      err_pulse   <= 1'b0;
      err_code    <= 3'd0;
      sum         <= 8'h00;
      idx         <= 8'h00;
      cnt         <= '0;
      cmd_r       <= 8'h00;
      len_r       <= 8'h00;
    end else begin
      err_pulse <= 1'b0;
      if (state == HOLD) begin
        cnt <= '0;
        if (byte_evt) begin
          err_pulse <= 1'b1;
          err_code  <= ERR_OVERRUN;
        end
        if (bus.frame_ack) begin
          state       <= HUNT0;
          frame_valid <= 1'b0;
        end
      end else if (bad_byte) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_LINE;
        state     <= HUNT0;
        cnt       <= '0;
      end else if (good_byte) begin
        cnt <= '0;
        case (state)
          HUNT0: begin
            if (bus.data_in == HDR0) state <= HUNT1;
          end
          HUNT1: begin
            if (bus.data_in == HDR1)      state <= CMD;
            else if (bus.data_in == HDR0) state <= HUNT1;
            else                          state <= HUNT0;
          end
          CMD: begin
            cmd_r <= bus.data_in;
            sum   <= bus.data_in;
            state <= LEN;
          end
          LEN: begin
            if (bus.data_in > 8'(MAX_LEN)) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_LENGTH;
              state     <= HUNT0;
            end else begin
              len_r <= bus.data_in;
              sum   <= sum + bus.data_in;
              idx   <= 8'h00;
              state <= (bus.data_in == 8'h00) ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            sum <= sum + bus.data_in;
            idx <= idx + 8'd1;
            if (idx == len_r - 8'd1) state <= CHK;
          end
          CHK: begin
            if (bus.data_in == sum) begin
              state       <= HOLD;
              cmd         <= cmd_r;
              len         <= len_r;
              frame_valid <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CHECKSUM;
              state     <= HUNT0;
            end
          end
          default: state <= HUNT0;
        endcase
      end else if (state == HUNT0) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= HUNT0;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Payload storage is deliberately unreset; only PAYLOAD writes it.
  always_ff @(posedge baud_clk) begin
    if (state == PAYLOAD && good_byte) buf_mem[idx[ADDR_W-1:0]] <= bus.data_in;
  end

  assign bus.rd_data     = ({1'b0, len} > 9'(bus.rd_addr)) ? buf_mem[bus.rd_addr] : 8'h00;
  assign bus.frame_valid = frame_valid;
  assign bus.cmd         = cmd;
  assign bus.len         = len;
  assign bus.err_pulse   = err_pulse;
  assign bus.err_code    = err_code;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames plus randomized frames whose
// expected outcome follows from how each frame was constructed.
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 2048;

  typedef struct packed {
    logic                      isErr;
    logic [2:0]                code;
    logic [7:0]                cmd;
    logic [7:0]                len;
    logic [MAX_LEN-1:0][7:0]   pay;
  } exp_t;

  logic baud_clk = 1'b0;
  logic rst;

  uart_frame_parser_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_parser #(
    .HDR0(8'h55), .HDR1(8'hAA), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .baud_clk(baud_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 baud_clk = ~baud_clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t lastFrame;
  int   recheckReq = 0;
  int   recheckDone = 0;
  int   cycle = 0;
  int   byteCycle = 0;
  int   lastErrCycle = 0;
  logic [7:0] txq[$];
  logic       txBad[$];

  always @(posedge baud_clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an unexpected DUT event, expected none", name);
  endtask

  // Drive one byte for a single cycle; a bad byte uses whichever error the line allows.
  task automatic applyStimulus(input logic [7:0] b, input logic bad);
    @(negedge baud_clk);
    bus.data_in   = b;
    bus.data_rcvd = 1'b1;
    if (bad) begin
      if (bus.parity_en && $urandom_range(0, 1) == 1) begin
        bus.dataerror  = 1'b1;
        bus.frameerror = 1'b0;
      end else begin
        bus.dataerror  = 1'b0;
        bus.frameerror = 1'b1;
      end
    end else begin
      bus.frameerror = 1'b0;
      bus.dataerror  = ~bus.parity_en;
    end
    byteCycle = cycle + 1;
    @(negedge baud_clk);
    bus.data_rcvd  = 1'b0;
    bus.frameerror = 1'b0;
    bus.dataerror  = 1'b0;
  endtask

  task automatic flushTx();
    while (txq.size() > 0) begin
      applyStimulus(txq.pop_front(), txBad.pop_front());
      repeat ($urandom_range(0, 2)) @(negedge baud_clk);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    txq.push_back(b);
    txBad.push_back(1'b0);
  endtask

  // Queue a complete frame; the checksum is the byte sum of CMD, LEN and payload.
  task automatic buildFrame(input exp_t e, input logic [7:0] chkDelta);
    int s;
    s = int'(e.cmd) + int'(e.len);
    pushByte(8'h55);
    pushByte(8'hAA);
    pushByte(e.cmd);
    pushByte(e.len);
    for (int i = 0; i < int'(e.len); i++) begin
      pushByte(e.pay[i]);
      s = s + int'(e.pay[i]);
    end
    pushByte(8'(s % 256) + chkDelta);
  endtask

  function automatic exp_t randFrame(input int maxLen);
    exp_t e;
    e       = '0;
    e.cmd   = 8'($urandom);
    e.len   = 8'($urandom_range(0, maxLen));
    for (int i = 0; i < int'(e.len); i++) e.pay[i] = 8'($urandom);
    return e;
  endfunction

  task automatic expectErr(input logic [2:0] code);
    exp_t e;
    e       = '0;
    e.isErr = 1'b1;
    e.code  = code;
    sb.push_back(e);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge baud_clk);
    if (sb.size() != 0) begin
      checkOutput("scoreboardDrain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic ackFrame();
    @(negedge baud_clk);
    bus.frame_ack = 1'b1;
    @(negedge baud_clk);
    bus.frame_ack = 1'b0;
    checkOutput("validAfterAck", 32'(bus.frame_valid), 32'd0);
  endtask

  task automatic sendGood(input exp_t e);
    sb.push_back(e);
    buildFrame(e, 8'h00);
    flushTx();
    waitIdle(300);
    ackFrame();
  endtask

  task automatic checkPayload(input exp_t e);
    logic [7:0] want;
    for (int a = 0; a < 2**ADDR_W && a <= int'(e.len); a++) begin
      bus.rd_addr = ADDR_W'(a);
      #1;
      want = (a < int'(e.len)) ? e.pay[a] : 8'h00;
      checkOutput($sformatf("rdData[%0d]", a), 32'(bus.rd_data), 32'(want));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises an error pulse or presents a frame.
  initial begin : monitor
    exp_t e;
    bit   frameSeen;
    frameSeen   = 1'b0;
    bus.rd_addr = '0;
    forever begin
      @(negedge baud_clk);
      if (rst) begin
        frameSeen = 1'b0;
      end else begin
        if (bus.err_pulse) begin
          lastErrCycle = cycle;
          if (sb.size() == 0) reportFail("unexpectedErr");
          else begin
            e = sb.pop_front();
            checkOutput("errKind", 32'(1), 32'(e.isErr));
            checkOutput("errCode", 32'(bus.err_code), 32'(e.code));
          end
        end
        if (bus.frame_valid && !frameSeen) begin
          frameSeen = 1'b1;
          if (sb.size() == 0) reportFail("unexpectedFrame");
          else begin
            e = sb[0];
            checkOutput("frameKind", 32'(0), 32'(e.isErr));
            if (!e.isErr) begin
              checkOutput("cmd", 32'(bus.cmd), 32'(e.cmd));
              checkOutput("len", 32'(bus.len), 32'(e.len));
              checkPayload(e);
              lastFrame = e;
            end
            e = sb.pop_front();
          end
        end
        if (recheckReq != recheckDone) begin
          checkPayload(lastFrame);
          recheckDone++;
        end
        if (!bus.frame_valid) frameSeen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    int   kind;
    int   pre;
    int   p;
    int   elapsed;

    rst            = 1'b1;
    bus.data_in    = 8'h00;
    bus.data_rcvd  = 1'b0;
    bus.dataerror  = 1'b0;
    bus.frameerror = 1'b0;
    bus.parity_en  = 1'b1;
    bus.frame_ack  = 1'b0;
    repeat (3) @(negedge baud_clk);
    checkOutput("resetValid", 32'(bus.frame_valid), 32'd0);
    checkOutput("resetErrPulse", 32'(bus.err_pulse), 32'd0);
    checkOutput("resetErrCode", 32'(bus.err_code), 32'd0);
    checkOutput("resetCmd", 32'(bus.cmd), 32'd0);
    checkOutput("resetLen", 32'(bus.len), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge baud_clk);

    $display("[TB] basic three-byte frame");
    e = '0; e.cmd = 8'h10; e.len = 8'd3;
    e.pay[0] = 8'h01; e.pay[1] = 8'h02; e.pay[2] = 8'h03;
    sendGood(e);

    $display("[TB] header resync, zero length, then bad checksum");
    pushByte(8'h55);
    e = '0; e.cmd = 8'h20; e.len = 8'd0;
    sb.push_back(e);
    buildFrame(e, 8'h00);
    flushTx();
    waitIdle(300);
    ackFrame();
    expectErr(3'd1);
    buildFrame(e, 8'h01);
    flushTx();
    waitIdle(100);
    checkOutput("noValidAfterBadChk", 32'(bus.frame_valid), 32'd0);

    $display("[TB] oversize length then recovery");
    expectErr(3'd4);
    pushByte(8'h55); pushByte(8'hAA); pushByte(8'h01); pushByte(8'h11);
    flushTx();
    waitIdle(100);
    e = '0; e.cmd = 8'h01; e.len = 8'd0;
    sendGood(e);
    e = randFrame(MAX_LEN); e.len = 8'(MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) e.pay[i] = 8'($urandom);
    sendGood(e);

    $display("[TB] line error mid-frame, parity disabled");
    expectErr(3'd2);
    pushByte(8'h55); pushByte(8'hAA); pushByte(8'h01); pushByte(8'h02);
    txq.push_back(8'h33); txBad.push_back(1'b1);
    flushTx();
    waitIdle(100);
    bus.parity_en = 1'b0;
    e = '0; e.cmd = 8'h5A; e.len = 8'd2; e.pay[0] = 8'hC3; e.pay[1] = 8'h3C;
    sendGood(e);
    bus.parity_en = 1'b1;

    $display("[TB] inter-byte timeout");
    expectErr(3'd3);
    pushByte(8'h55); pushByte(8'hAA); pushByte(8'h01);
    flushTx();
    waitIdle(TIMEOUT + 100);
    elapsed = lastErrCycle - byteCycle;
    checkOutput("timeoutNotEarly", 32'(elapsed >= TIMEOUT - 2), 32'd1);
    checkOutput("timeoutNotLate", 32'(elapsed <= TIMEOUT + 1), 32'd1);

    $display("[TB] reset mid-frame");
    pushByte(8'h55); pushByte(8'hAA); pushByte(8'h01); pushByte(8'h02); pushByte(8'h05);
    flushTx();
    @(negedge baud_clk);
    rst = 1'b1;
    @(negedge baud_clk);
    checkOutput("midResetValid", 32'(bus.frame_valid), 32'd0);
    checkOutput("midResetErrCode", 32'(bus.err_code), 32'd0);
    checkOutput("midResetCmd", 32'(bus.cmd), 32'd0);
    rst = 1'b0;
    @(negedge baud_clk);
    e = '0; e.cmd = 8'h77; e.len = 8'd1; e.pay[0] = 8'hEE;
    sendGood(e);

    $display("[TB] overrun while holding a frame");
    e = '0; e.cmd = 8'h33; e.len = 8'd2; e.pay[0] = 8'hA1; e.pay[1] = 8'hB2;
    sb.push_back(e);
    buildFrame(e, 8'h00);
    flushTx();
    waitIdle(300);
    expectErr(3'd5);
    pushByte(8'h77);
    flushTx();
    waitIdle(50);
    checkOutput("overrunValid", 32'(bus.frame_valid), 32'd1);
    checkOutput("overrunCmd", 32'(bus.cmd), 32'h33);
    checkOutput("overrunLen", 32'(bus.len), 32'd2);
    recheckReq++;
    for (int i = 0; i < 100 && recheckDone != recheckReq; i++) @(negedge baud_clk);
    checkOutput("recheckDone", 32'(recheckDone), 32'(recheckReq));
    expectErr(3'd5);
    @(negedge baud_clk);
    bus.data_in   = 8'h55;
    bus.data_rcvd = 1'b1;
    bus.frame_ack = 1'b1;
    @(negedge baud_clk);
    bus.data_rcvd = 1'b0;
    bus.frame_ack = 1'b0;
    checkOutput("ackWithByteValid", 32'(bus.frame_valid), 32'd0);
    waitIdle(50);
    checkOutput("cmdKeptAfterAck", 32'(bus.cmd), 32'h33);
    checkOutput("lenKeptAfterAck", 32'(bus.len), 32'd2);
    e = '0; e.cmd = 8'h44; e.len = 8'd1; e.pay[0] = 8'h09;
    sendGood(e);

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      kind          = $urandom_range(0, 5);
      bus.parity_en = 1'($urandom_range(0, 1));
      pre           = $urandom_range(0, 2);
      for (int i = 0; i < pre; i++) begin
        p = $urandom_range(0, 255);
        if (p == 8'h55) p = 8'h12;
        pushByte(8'(p));
      end
      if ($urandom_range(0, 3) == 0) begin
        pushByte(8'h55);
        pre++;
      end
      e = randFrame(MAX_LEN);
      case (kind)
        3: begin
          expectErr(3'd1);
          buildFrame(e, 8'($urandom_range(1, 255)));
        end
        4: begin
          expectErr(3'd4);
          pushByte(8'h55); pushByte(8'hAA); pushByte(e.cmd);
          pushByte(8'($urandom_range(MAX_LEN + 1, 255)));
        end
        5: begin
          expectErr(3'd2);
          buildFrame(e, 8'h00);
          p = $urandom_range(pre, txq.size() - 1);
          while (txq.size() > p + 1) begin
            void'(txq.pop_back());
            void'(txBad.pop_back());
          end
          txBad[p] = 1'b1;
        end
        default: begin
          sb.push_back(e);
          buildFrame(e, 8'h00);
        end
      endcase
      flushTx();
      waitIdle(300);
      if (kind <= 2) ackFrame();
    end

    repeat (10) @(negedge baud_clk);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Byte-level command frame parser sitting directly downstream of the UART receiver, in the same baud_clk domain (16x baud). Consumes received bytes and strobes, hunts for a two-byte header, and collects CMD, LEN, payload and checksum into a local buffer. Presents validated frames to the motion-control command decoder through a valid/ack handshake. Reports line, checksum, length, timeout and overrun errors.

Parameters:
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte
MAX_LEN, 16, maximum payload bytes (1..255)
ADDR_W, 4, payload read-address width; 2**ADDR_W >= MAX_LEN
TIMEOUT, 2048, max baud_clk cycles between bytes inside a frame

Ports:
baud_clk  in  1  clock, 16x baud sampling clock
rst  in  1  asynchronous reset, active-high
data_in  in  8  received byte from UART receiver
data_rcvd  in  1  one-cycle byte-received strobe; data_in valid this cycle
dataerror  in  1  parity error for current byte; qualified by parity_en
frameerror  in  1  stop-bit error for current byte
parity_en  in  1  parity enabled (same signal as receiver)
frame_ack  in  1  consumer has taken the frame
rd_addr  in  ADDR_W  payload read address
rd_data  out  8  payload byte at rd_addr (combinational)
frame_valid  out  1  validated frame held on cmd/len/payload
cmd  out  8  command byte of held frame
len  out  8  payload length of held frame
err_pulse  out  1  one-cycle error strobe
err_code  out  3  1=checksum, 2=line, 3=timeout, 4=length, 5=overrun; holds last code

Behaviour:
- Reset (async, rst=1): state HUNT0; frame_valid, cmd, len, err_pulse, err_code, checksum, index and timeout counter = 0. Buffer contents are not reset. Reset mid-frame discards the frame.
- "Byte event" = data_rcvd=1. "Bad byte" = byte event with frameerror=1 or (parity_en & dataerror)=1.
- Bad byte in any state except HOLD: discard, err_code=2, go to HUNT0.
- FSM on good byte events:
  - HUNT0: byte==HDR0 -> HUNT1; otherwise stay.
  - HUNT1: byte==HDR1 -> CMD; byte==HDR0 -> stay in HUNT1; otherwise -> HUNT0.
  - CMD: latch internal cmd_r; sum=byte -> LEN.
  - LEN: byte>MAX_LEN -> err_code=4, HUNT0. Otherwise latch len_r; sum+=byte; idx=0; byte==0 -> CHK, else -> PAYLOAD.
  - PAYLOAD: buf[idx]=byte; sum+=byte; idx++; after writing idx==len_r-1 -> CHK.
  - CHK: byte==sum[7:0] -> HOLD, with cmd<=cmd_r, len<=len_r and frame_valid<=1 on the same edge. Else err_code=1, HUNT0.
  - HOLD: frame_valid=1; cmd/len/buffer stable. frame_ack=1 -> HUNT0, frame_valid=0 next cycle. Any byte event in HOLD (good or bad) is dropped with err_code=5; if frame_ack is in the same cycle, the ack is still honoured.
- Checksum: 8-bit modulo-256 sum of CMD, LEN and all payload bytes; header bytes are excluded.
- Timeout: counter clears on every byte event and increments each cycle in HUNT1, CMD, LEN, PAYLOAD and CHK. On reaching TIMEOUT-1 with no byte event: err_code=3, go to HUNT0, counter cleared. Counter is held at 0 in HUNT0 and HOLD.
- Errors: err_pulse is high exactly one cycle, on the clock edge after the causing event, with err_code updated on the same edge. At most one error per cycle; priority: line > length > checksum; overrun and timeout are mutually exclusive with these by state.
- cmd/len outputs change only on CHK success; they keep the last good frame after ack.
- rd_data = buf[rd_addr] when rd_addr < len, else 8'h00. This is combinational.
- frame_ack outside HOLD is ignored.
- Buffer is written only in PAYLOAD, so a held frame is never corrupted.

Test Plan:
- Bytes 55 AA 10 03 01 02 03 19 -> frame_valid=1, cmd=8'h10, len=3, rd_data at addr 0/1/2 = 01/02/03, addr 3 -> 00; frame_ack -> frame_valid=0 next cycle.
- 55 55 AA 20 00 20 -> valid frame (header resync), cmd=8'h20, len=0; then 55 AA 20 00 21 -> err_pulse with err_code=1, no frame_valid.
- 55 AA 01 11 (LEN=17 > MAX_LEN) -> err_code=4 at LEN; the following 55 AA 01 00 01 is accepted.
- 55 AA 01 02 then frameerror=1 on next byte -> err_code=2, state HUNT0; with parity_en=0, dataerror=1 is ignored.
- 55 AA 01 then no byte for 2048 cycles -> err_code=3 at cycle TIMEOUT-1; apply rst mid-frame -> frame_valid=0, clean restart.
- Valid frame held, no ack, extra byte arrives -> err_code=5, cmd/len/buffer unchanged; byte and frame_ack in the same cycle -> ack honoured, byte dropped.
